// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, excepttype codes, ExcCode values and
// Status/Cause field positions used by the CP0 block and the pipeline control unit.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;

    // Codes 0x1..0x8 are interrupts (highest pending IP bit + 1)
    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_SYSCALL = 32'h9;
    localparam logic [31:0] EXC_RI      = 32'ha;
    localparam logic [31:0] EXC_OV      = 32'hb;
    localparam logic [31:0] EXC_TRAP    = 32'hc;
    localparam logic [31:0] EXC_ERET    = 32'hd;

    typedef enum logic [4:0] {
        EXCCODE_INT = 5'd0,
        EXCCODE_SYS = 5'd8,
        EXCCODE_RI  = 5'd10,
        EXCCODE_OV  = 5'd12,
        EXCCODE_TR  = 5'd13
    } exccode_t;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LO   = 8;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_IP_LO    = 8;
    localparam int CAUSE_EXC_LO   = 2;

    function automatic logic [31:0] int_excepttype(input logic [7:0] pending);
        logic [31:0] code;
        code = EXC_NONE;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) code = 32'(i + 1);
        end
        return code;
    endfunction

    function automatic exccode_t exccode_of(input logic [31:0] code);
        exccode_t ec;
        case (code)
            EXC_SYSCALL: ec = EXCCODE_SYS;
            EXC_RI:      ec = EXCCODE_RI;
            EXC_OV:      ec = EXCCODE_OV;
            EXC_TRAP:    ec = EXCCODE_TR;
            default:     ec = EXCCODE_INT;
        endcase
        return ec;
    endfunction

endpackage

// File: rtl/cp0_except_if.sv
// Pipeline-side connection to CP0: MEM-stage flags, WB mtc0 port, mfc0 read port
// and the exception/EPC/timer results.
interface cp0_except_if;
    import cp0_pkg::*;

    logic [5:0]  hw_int;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delay_slot;
    logic        mem_syscall;
    logic        mem_ri;
    logic        mem_ov;
    logic        mem_trap;
    logic        mem_eret;
    logic        mem_stall;
    logic        wb_cp0_we;
    logic [4:0]  wb_cp0_waddr;
    logic [31:0] wb_cp0_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] mem_excepttype;
    logic [31:0] cp0_epc;
    logic        timer_irq;

    modport master (
        output hw_int, mem_valid, mem_pc, mem_in_delay_slot,
               mem_syscall, mem_ri, mem_ov, mem_trap, mem_eret, mem_stall,
               wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, rd_addr,
        input  rd_data, mem_excepttype, cp0_epc, timer_irq
    );

    modport slave (
        input  hw_int, mem_valid, mem_pc, mem_in_delay_slot,
               mem_syscall, mem_ri, mem_ov, mem_trap, mem_eret, mem_stall,
               wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, rd_addr,
        output rd_data, mem_excepttype, cp0_epc, timer_irq
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match arms a sticky interrupt
// that is only cleared by rewriting Compare.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [4:0]         waddr,
    input  logic [31:0]        wdata,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] compare,
    output logic               timer_irq
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;
    logic [COUNT_W-1:0] compare_reg;
    logic               armed_reg;
    logic               irq_reg;
    logic               count_we;
    logic               compare_we;

    assign count_we   = we && (waddr == CP0_REG_COUNT);
    assign compare_we = we && (waddr == CP0_REG_COMPARE);

    always_comb begin
        count_next = count_reg + COUNT_ONE;
        if (count_we) count_next = wdata[COUNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg   <= '0;
            compare_reg <= '0;
            armed_reg   <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            count_reg <= count_next;
            // Compare write wins over a same-cycle match so software can always clear
            if (compare_we) begin
                compare_reg <= wdata[COUNT_W-1:0];
                armed_reg   <= 1'b1;
                irq_reg     <= 1'b0;
            end else if (armed_reg && (count_next == compare_reg)) begin
                irq_reg <= 1'b1;
            end
        end
    end

    assign count     = count_reg;
    assign compare   = compare_reg;
    assign timer_irq = irq_reg;

endmodule

// File: rtl/cp0_except.sv
// CP0 Status/Cause/EPC state with MEM-stage exception arbitration, eret EPC
// forwarding and mfc0/mtc0 access; Count/Compare live in cp0_timer.
module cp0_except
    import cp0_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    cp0_except_if.slave  bus
);

    logic               ie_reg;
    logic               exl_reg;
    logic [7:0]         im_reg;
    logic               bd_reg;
    logic [1:0]         ip_sw_reg;
    logic [5:0]         hw_sample_reg;
    exccode_t           exccode_reg;
    logic [31:0]        epc_reg;

    logic [COUNT_W-1:0] timer_count;
    logic [COUNT_W-1:0] timer_compare;
    logic               timer_irq;
    logic [7:0]         ip;
    logic [7:0]         pending;
    logic               int_eligible;
    logic [31:0]        excepttype;
    logic               commit;
    logic [31:0]        status_word;
    logic [31:0]        cause_word;
    logic [31:0]        rd_data;

    cp0_timer #(.COUNT_W(COUNT_W)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (bus.wb_cp0_we),
        .waddr     (bus.wb_cp0_waddr),
        .wdata     (bus.wb_cp0_wdata),
        .count     (timer_count),
        .compare   (timer_compare),
        .timer_irq (timer_irq)
    );

    // IP[6:2] mirror the registered hw_int[4:0] sample; IP[7] merges hw_int[5] and the timer
    assign ip[1:0] = ip_sw_reg;
    for (genvar gi = 0; gi < 5; gi++) begin : g_ip_hw
        assign ip[gi+2] = hw_sample_reg[gi];
    end
    assign ip[7] = hw_sample_reg[5] | timer_irq;

    assign pending      = ip & im_reg;
    assign int_eligible = ie_reg && !exl_reg && bus.mem_valid && (pending != 8'h0);

    always_comb begin
        excepttype = EXC_NONE;
        if (int_eligible) begin
            excepttype = int_excepttype(pending);
        end else if (bus.mem_valid) begin
            if (bus.mem_ri)           excepttype = EXC_RI;
            else if (bus.mem_syscall) excepttype = EXC_SYSCALL;
            else if (bus.mem_ov)      excepttype = EXC_OV;
            else if (bus.mem_trap)    excepttype = EXC_TRAP;
            else if (bus.mem_eret)    excepttype = EXC_ERET;
        end
    end

    assign commit = !bus.mem_stall && (excepttype != EXC_NONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ie_reg        <= 1'b0;
            exl_reg       <= 1'b0;
            im_reg        <= 8'h0;
            bd_reg        <= 1'b0;
            ip_sw_reg     <= 2'b0;
            hw_sample_reg <= 6'h0;
            exccode_reg   <= EXCCODE_INT;
            epc_reg       <= 32'h0;
        end else begin
            hw_sample_reg <= bus.hw_int;
            if (bus.wb_cp0_we) begin
                case (bus.wb_cp0_waddr)
                    CP0_REG_STATUS: begin
                        ie_reg  <= bus.wb_cp0_wdata[STATUS_IE_BIT];
                        exl_reg <= bus.wb_cp0_wdata[STATUS_EXL_BIT];
                        im_reg  <= bus.wb_cp0_wdata[STATUS_IM_LO +: 8];
                    end
                    CP0_REG_CAUSE: ip_sw_reg <= bus.wb_cp0_wdata[CAUSE_IP_LO +: 2];
                    CP0_REG_EPC:   epc_reg   <= bus.wb_cp0_wdata;
                    default: ;
                endcase
            end
            // Later assignments win, so commit overrides only the fields it owns
            if (commit) begin
                if (excepttype == EXC_ERET) begin
                    exl_reg <= 1'b0;
                end else begin
                    if (!exl_reg) begin
                        epc_reg <= bus.mem_in_delay_slot ? (bus.mem_pc - 32'd4) : bus.mem_pc;
                        bd_reg  <= bus.mem_in_delay_slot;
                    end
                    exl_reg     <= 1'b1;
                    exccode_reg <= exccode_of(excepttype);
                end
            end
        end
    end

    always_comb begin
        status_word = 32'h0;
        status_word[STATUS_IE_BIT]     = ie_reg;
        status_word[STATUS_EXL_BIT]    = exl_reg;
        status_word[STATUS_IM_LO +: 8] = im_reg;
        cause_word = 32'h0;
        cause_word[CAUSE_BD_BIT]       = bd_reg;
        cause_word[CAUSE_IP_LO +: 8]   = ip;
        cause_word[CAUSE_EXC_LO +: 5]  = exccode_reg;
    end

    always_comb begin
        rd_data = 32'h0;
        case (bus.rd_addr)
            CP0_REG_COUNT:   rd_data = 32'(timer_count);
            CP0_REG_COMPARE: rd_data = 32'(timer_compare);
            CP0_REG_STATUS:  rd_data = status_word;
            CP0_REG_CAUSE:   rd_data = cause_word;
            CP0_REG_EPC:     rd_data = epc_reg;
            default:         rd_data = 32'h0;
        endcase
    end

    assign bus.rd_data        = rd_data;
    assign bus.mem_excepttype = excepttype;
    assign bus.cp0_epc        = (bus.wb_cp0_we && (bus.wb_cp0_waddr == CP0_REG_EPC))
                                ? bus.wb_cp0_wdata : epc_reg;
    assign bus.timer_irq      = timer_irq;

endmodule

// File: tb/tb_cp0_except.sv
// Scoreboard bench for cp0_except: a behavioural CP0 model predicts every cycle's
// outputs, a separate monitor compares them at the falling edge.
module tb_cp0_except;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cp0_except_if bus();

    cp0_except #(.COUNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] code;
        logic [31:0] epc;
        logic [31:0] rdata;
        logic        irq;
        logic [4:0]  raddr;
        int unsigned seq;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned seq = 0;

    // Architectural model state
    logic [31:0] m_status, m_epc, m_count, m_compare;
    logic        m_bd, m_armed, m_irq;
    logic [1:0]  m_ip_sw;
    logic [5:0]  m_hw;
    logic [4:0]  m_exc;

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_irq, m_hw[4:0], m_ip_sw};
    endfunction

    function automatic logic [31:0] m_code();
        logic [7:0] pend;
        pend = m_ip() & m_status[15:8];
        if (m_status[0] && !m_status[1] && bus.mem_valid && pend != 8'h0) begin
            for (int i = 7; i >= 0; i--) if (pend[i]) return 32'(i + 1);
        end
        if (!bus.mem_valid)  return 32'h0;
        if (bus.mem_ri)      return 32'ha;
        if (bus.mem_syscall) return 32'h9;
        if (bus.mem_ov)      return 32'hb;
        if (bus.mem_trap)    return 32'hc;
        if (bus.mem_eret)    return 32'hd;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_rd();
        case (bus.rd_addr)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {m_bd, 15'h0, m_ip(), 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [4:0] m_exccode(input logic [31:0] code);
        if (code <= 32'h8)  return 5'd0;
        if (code == 32'h9)  return 5'd8;
        if (code == 32'ha)  return 5'd10;
        if (code == 32'hb)  return 5'd12;
        return 5'd13;
    endfunction

    task automatic model_zero();
        m_status = 0; m_epc = 0; m_count = 0; m_compare = 0;
        m_bd = 0; m_armed = 0; m_irq = 0; m_ip_sw = 0; m_hw = 0; m_exc = 0;
    endtask

    // Predict this cycle's outputs, advance the model across the clock edge
    task automatic cycle();
        exp_t        e;
        logic [31:0] code, cnt_n;
        logic        old_exl, we;
        code    = m_code();
        we      = bus.wb_cp0_we;
        e.code  = code;
        e.epc   = (we && bus.wb_cp0_waddr == 5'd14) ? bus.wb_cp0_wdata : m_epc;
        e.rdata = m_rd();
        e.irq   = m_irq;
        e.raddr = bus.rd_addr;
        e.seq   = seq;
        seq++;
        sb.push_back(e);
        if (!reset_n) begin
            model_zero();
        end else begin
            cnt_n = (we && bus.wb_cp0_waddr == 5'd9) ? bus.wb_cp0_wdata : m_count + 1;
            if (we && bus.wb_cp0_waddr == 5'd11) begin
                m_compare = bus.wb_cp0_wdata; m_armed = 1; m_irq = 0;
            end else if (m_armed && cnt_n == m_compare) begin
                m_irq = 1;
            end
            m_count = cnt_n;
            old_exl = m_status[1];
            if (we) begin
                case (bus.wb_cp0_waddr)
                    5'd12:   m_status = bus.wb_cp0_wdata & 32'h0000ff03;
                    5'd13:   m_ip_sw  = bus.wb_cp0_wdata[9:8];
                    5'd14:   m_epc    = bus.wb_cp0_wdata;
                    default: ;
                endcase
            end
            if (!bus.mem_stall && code != 0) begin
                if (code == 32'hd) begin
                    m_status[1] = 0;
                end else begin
                    if (!old_exl) begin
                        m_epc = bus.mem_in_delay_slot ? bus.mem_pc - 4 : bus.mem_pc;
                        m_bd  = bus.mem_in_delay_slot;
                    end
                    m_status[1] = 1;
                    m_exc = m_exccode(code);
                end
            end
            m_hw = bus.hw_int;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.hw_int = 0; bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_in_delay_slot = 0;
        bus.mem_syscall = 0; bus.mem_ri = 0; bus.mem_ov = 0; bus.mem_trap = 0;
        bus.mem_eret = 0; bus.mem_stall = 0; bus.wb_cp0_we = 0; bus.wb_cp0_waddr = 0;
        bus.wb_cp0_wdata = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.wb_cp0_we = 1; bus.wb_cp0_waddr = a; bus.wb_cp0_wdata = d;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input int unsigned s);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d: got %08h expected %08h", name, s, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle, away from the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("txn %0d code %0h epc %08h rd[%0d] %08h irq %0b", e.seq,
                         bus.mem_excepttype, bus.cp0_epc, e.raddr, bus.rd_data, bus.timer_irq);
                cmp("excepttype", bus.mem_excepttype, e.code, e.seq);
                cmp("cp0_epc", bus.cp0_epc, e.epc, e.seq);
                cmp("rd_data", bus.rd_data, e.rdata, e.seq);
                cmp("timer_irq", 32'(bus.timer_irq), 32'(e.irq), e.seq);
            end
        end
    end

    logic [4:0] addr_pool [6];

    initial begin
        addr_pool[0] = 5'd9;  addr_pool[1] = 5'd11; addr_pool[2] = 5'd12;
        addr_pool[3] = 5'd13; addr_pool[4] = 5'd14; addr_pool[5] = 5'd0;
        clear();
        bus.rd_addr = 0;
        reset_n = 0;
        @(posedge clk); @(posedge clk); #1;
        model_zero();

        // Reset state
        cycle();
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin bus.rd_addr = addr_pool[i]; cycle(); end

        // Syscall
        bus.mem_valid = 1; bus.mem_syscall = 1; bus.mem_pc = 32'h00400010; bus.rd_addr = 14;
        cycle();
        clear();
        for (int i = 2; i < 5; i++) begin bus.rd_addr = addr_pool[i]; cycle(); end

        // Delay slot with RI beating Ov (leave EXL first)
        bus.mem_valid = 1; bus.mem_eret = 1; cycle(); clear();
        bus.mem_valid = 1; bus.mem_ov = 1; bus.mem_ri = 1; bus.mem_in_delay_slot = 1;
        bus.mem_pc = 32'h00400024;
        cycle();
        clear();
        bus.rd_addr = 14; cycle();
        bus.rd_addr = 13; cycle();

        // Timer: Status = IE|IM7, Compare = Count + 5, stall keeps EXL clear
        bus.mem_valid = 1; bus.mem_eret = 1; cycle(); clear();
        mtc0(5'd12, 32'h00008001); cycle();
        mtc0(5'd11, m_count + 5);  cycle(); clear();
        bus.mem_valid = 1; bus.mem_stall = 1; bus.rd_addr = 9;
        for (int i = 0; i < 7; i++) cycle();
        mtc0(5'd11, m_count + 1000); cycle();
        bus.wb_cp0_we = 0; cycle(); cycle();
        clear();

        // Masking by EXL, then eret exposes hw_int[0] as code 3
        mtc0(5'd12, 32'h00000401); cycle(); clear();
        bus.mem_valid = 1; bus.mem_syscall = 1; cycle(); clear();
        bus.hw_int = 6'h01; bus.mem_valid = 1; bus.rd_addr = 13;
        cycle(); cycle();
        bus.mem_eret = 1; cycle();
        bus.mem_eret = 0; bus.rd_addr = 12; cycle(); cycle();
        clear();

        // Stall holds commit for 3 cycles while Count advances
        mtc0(5'd12, 32'h0); cycle(); clear();
        bus.mem_valid = 1; bus.mem_syscall = 1; bus.mem_pc = 32'h00400100;
        bus.mem_stall = 1; bus.rd_addr = 9;
        cycle(); cycle(); cycle();
        bus.mem_stall = 0; bus.rd_addr = 14; cycle();
        clear();
        bus.rd_addr = 14; cycle();
        bus.rd_addr = 12; cycle();

        // EPC forward alongside eret
        mtc0(5'd14, 32'hBFC00100); bus.mem_valid = 1; bus.mem_eret = 1; cycle();
        clear(); bus.rd_addr = 14; cycle();
        bus.rd_addr = 12; cycle();

        // Reset in the middle of an exception
        bus.mem_valid = 1; bus.mem_syscall = 1; bus.mem_pc = 32'h00400200;
        mtc0(5'd13, 32'h00000300); reset_n = 0; cycle();
        reset_n = 1; clear();
        for (int i = 0; i < 6; i++) begin bus.rd_addr = addr_pool[i]; cycle(); end

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            bus.mem_valid = ($urandom_range(0, 3) != 0);
            bus.mem_pc = $urandom() & 32'hfffffffc;
            bus.mem_in_delay_slot = ($urandom_range(0, 3) == 0);
            bus.mem_syscall = ($urandom_range(0, 7) == 0);
            bus.mem_ri = ($urandom_range(0, 7) == 0);
            bus.mem_ov = ($urandom_range(0, 7) == 0);
            bus.mem_trap = ($urandom_range(0, 7) == 0);
            bus.mem_eret = ($urandom_range(0, 5) == 0);
            bus.mem_stall = ($urandom_range(0, 4) == 0);
            bus.hw_int = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'h0;
            bus.wb_cp0_we = ($urandom_range(0, 3) == 0);
            bus.wb_cp0_waddr = ($urandom_range(0, 5) == 5) ? 5'($urandom_range(0, 31))
                                                          : addr_pool[$urandom_range(0, 4)];
            bus.wb_cp0_wdata = $urandom();
            if (bus.wb_cp0_waddr == 5'd11 && $urandom_range(0, 1) == 1)
                bus.wb_cp0_wdata = m_count + 32'($urandom_range(1, 6));
            bus.rd_addr = ($urandom_range(0, 5) == 5) ? 5'($urandom_range(0, 31))
                                                     : addr_pool[$urandom_range(0, 4)];
            reset_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset_n = 1;
        clear();

        @(negedge clk); #1;
        cmp("scoreboard_drained", 32'(sb.size()), 32'h0, seq);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
